frame_bank_arbiter: RTL

Parametrised two-bank ZBT SRAM arbiter for NUM_CLIENTS frame-buffer clients. It sits between the capture, filter, transform and display blocks and the two zbt_6111 wrappers. Each client owns one frame buffer; the client→buffer mapping rotates one step on every frame_flag. The block arbitrates per bank (fixed-priority or round-robin), registers the SRAM command, and routes read data back to the issuing client through tagged per-bank return pipelines.

---
 rtl/frame_bank_arbiter_if.sv | 26 ++
 rtl/frame_bank_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/frame_bank_arbiter_if.sv
// Client-side bus of the frame bank arbiter: per-client request/grant plus tagged read return.
// req/grant: an access transfers in the cycle where req[i] && grant[i]; a client keeps req
// asserted with stable wr/addr/wdata until granted, and rdata_valid[i] is a one-cycle pulse.
interface frame_bank_arbiter_if #(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 36
);
  logic [NUM_CLIENTS-1:0]        req;
  logic [NUM_CLIENTS-1:0]        wr;
  logic [NUM_CLIENTS*ADDR_W-1:0] addr;
  logic [NUM_CLIENTS*DATA_W-1:0] wdata;
  logic [NUM_CLIENTS-1:0]        grant;
  logic [NUM_CLIENTS-1:0]        rdata_valid;
  logic [NUM_CLIENTS*DATA_W-1:0] rdata;

  modport master (
    output req, wr, addr, wdata,
    input  grant, rdata_valid, rdata
  );

  modport slave (
    input  req, wr, addr, wdata,
    output grant, rdata_valid, rdata
  );
endinterface

// File: rtl/frame_bank_arbiter.sv
// Two-bank ZBT arbiter: rotating client->frame-buffer map, per-bank fixed/round-robin winner,
// registered SRAM command and tagged read-return pipelines that route data to the issuer.
module frame_bank_arbiter #(
  parameter int NUM_CLIENTS  = 4,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 36,
  parameter int IMAGE_LENGTH = 76800,
  parameter int READ_LATENCY = 2,
  parameter int RR_MODE      = 0,
  parameter int BID_W        = $clog2(NUM_CLIENTS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_flag,
  frame_bank_arbiter_if.slave          bus,
  output logic [ADDR_W-1:0]            mem0_addr,
  output logic [ADDR_W-1:0]            mem1_addr,
  output logic [DATA_W-1:0]            mem0_write,
  output logic [DATA_W-1:0]            mem1_write,
  output logic                         mem0_wr,
  output logic                         mem1_wr,
  output logic                         mem0_en,
  output logic                         mem1_en,
  input  logic [DATA_W-1:0]            mem0_read,
  input  logic [DATA_W-1:0]            mem1_read,
  output logic [NUM_CLIENTS*BID_W-1:0] buf_map
);

  localparam int TAG_D = READ_LATENCY + 1;

  logic [BID_W-1:0]              buf_id   [NUM_CLIENTS];
  logic [BID_W-1:0]              rr_ptr   [2];
  logic [1:0]                    win_vld;
  logic [BID_W-1:0]              win_idx  [2];
  logic [NUM_CLIENTS-1:0]        grant_raw;
  logic [ADDR_W-1:0]             sel_addr [2];
  logic [DATA_W-1:0]             sel_data [2];
  logic [1:0]                    sel_wr;
  logic [ADDR_W-1:0]             cmd_addr [2];
  logic [DATA_W-1:0]             cmd_data [2];
  logic [1:0]                    cmd_wr;
  logic [1:0]                    cmd_en;
  logic [TAG_D-1:0]              tag_vld  [2];
  logic [BID_W-1:0]              tag_cid  [2][TAG_D];
  logic [DATA_W-1:0]             mem_rd   [2];
  logic [NUM_CLIENTS-1:0]        rvalid_q;
  logic [NUM_CLIENTS*DATA_W-1:0] rdata_q;

  // Buffer id upper bits select the frame slot inside the bank; overflow wraps at ADDR_W.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [BID_W-1:0] id,
                                                  input logic [ADDR_W-1:0] off);
    logic [31:0] loc;
    loc = 32'(id >> 1);
    return ADDR_W'(loc * 32'(IMAGE_LENGTH) + 32'(off));
  endfunction

  always_comb begin : arb
    int idx;
    idx     = 0;
    win_vld = '0;
    for (int b = 0; b < 2; b++) begin
      win_idx[b] = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
        idx = ((RR_MODE != 0 ? int'(rr_ptr[b]) : 0) + k) % NUM_CLIENTS;
        if (!win_vld[b] && bus.req[idx] && (buf_id[idx][0] == 1'(b))) begin
          win_vld[b] = 1'b1;
          win_idx[b] = BID_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_raw = '0;
    sel_wr    = '0;
    for (int b = 0; b < 2; b++) begin
      sel_addr[b] = phys_addr(buf_id[win_idx[b]],
                              bus.addr[int'(win_idx[b])*ADDR_W +: ADDR_W]);
      sel_data[b] = bus.wdata[int'(win_idx[b])*DATA_W +: DATA_W];
      sel_wr[b]   = bus.wr[win_idx[b]];
      if (win_vld[b]) grant_raw[win_idx[b]] = 1'b1;
    end
  end

  assign bus.grant = grant_raw & {NUM_CLIENTS{reset}};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        cmd_addr[b] <= '0;
        cmd_data[b] <= '0;
      end
      cmd_wr <= '0;
      cmd_en <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        cmd_en[b]   <= win_vld[b];
        cmd_wr[b]   <= win_vld[b] & sel_wr[b];
        cmd_addr[b] <= win_vld[b] ? sel_addr[b] : '0;
        cmd_data[b] <= win_vld[b] ? sel_data[b] : '0;
      end
    end
  end

  // Map rotation takes effect next cycle; rr_ptr is only consulted in round-robin mode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CLIENTS; i++) buf_id[i] <= BID_W'(i);
      for (int b = 0; b < 2; b++) rr_ptr[b] <= '0;
    end else begin
      if (frame_flag) begin
        for (int i = 0; i < NUM_CLIENTS; i++) buf_id[i] <= buf_id[(i + 1) % NUM_CLIENTS];
      end
      for (int b = 0; b < 2; b++) begin
        if (win_vld[b]) rr_ptr[b] <= BID_W'((int'(win_idx[b]) + 1) % NUM_CLIENTS);
      end
    end
  end

  // Tags carry the client index so reads in flight across a rotation still reach their issuer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        tag_vld[b] <= '0;
        for (int k = 0; k < TAG_D; k++) tag_cid[b][k] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        for (int k = TAG_D - 1; k >= 1; k--) begin
          tag_vld[b][k] <= tag_vld[b][k-1];
          tag_cid[b][k] <= tag_cid[b][k-1];
        end
        tag_vld[b][0] <= win_vld[b] & ~sel_wr[b];
        tag_cid[b][0] <= win_idx[b];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      for (int b = 0; b < 2; b++) begin
        if (tag_vld[b][TAG_D-1]) begin
          rvalid_q[tag_cid[b][TAG_D-1]] <= 1'b1;
          rdata_q[int'(tag_cid[b][TAG_D-1])*DATA_W +: DATA_W] <= mem_rd[b];
        end
      end
    end
  end

  always_comb begin
    buf_map = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) buf_map[i*BID_W +: BID_W] = buf_id[i];
  end

  assign mem_rd[0]       = mem0_read;
  assign mem_rd[1]       = mem1_read;
  assign bus.rdata_valid = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign mem0_addr       = cmd_addr[0];
  assign mem1_addr       = cmd_addr[1];
  assign mem0_write      = cmd_data[0];
  assign mem1_write      = cmd_data[1];
  assign mem0_wr         = cmd_wr[0];
  assign mem1_wr         = cmd_wr[1];
  assign mem0_en         = cmd_en[0];
  assign mem1_en         = cmd_en[1];

endmodule
